intpol2_iq_out_pacer: RTL and testbench

INTPOL2_IQ_OUT_PACER -- requirements
Module: intpol2_iq_out_pacer

---
 rtl/intpol2_iq_out_pacer.sv | 174 +++++++++++++++++
 tb/tb_intpol2_iq_out_pacer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intpol2_iq_out_pacer.sv
// Paced I/Q output stage: a shared I/Q FIFO fed by the interpolator and drained one
// sample every period_i clocks. Optional macro INTPOL2_OUT_UNDERRUN_HOLD_EN repeats the last sample on underrun.
module intpol2_iq_out_pacer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_MARGIN  = 2
) (
    input  logic                    clk,
    input  logic                    rst_a,
    input  logic                    en_i,
    input  logic [15:0]             period_i,
    input  logic [ADDR_WIDTH:0]     prime_i,
    input  logic                    clr_flags_i,
    input  logic                    Write_enable_i,
    input  logic [DATA_WIDTH-1:0]   I_interp_i,
    input  logic [DATA_WIDTH-1:0]   Q_interp_i,
    output logic                    Afull_o,
    output logic [DATA_WIDTH-1:0]   I_o,
    output logic [DATA_WIDTH-1:0]   Q_o,
    output logic                    valid_o,
    output logic [ADDR_WIDTH:0]     level_o,
    output logic [1:0]              state_o,
    output logic                    underrun_o,
    output logic                    overflow_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] L_AF    = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_WIDTH:0] L_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] L_ZERO  = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [2*DATA_WIDTH-1:0]     r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]       r_wptr;
    logic [ADDR_WIDTH-1:0]       r_rptr;
    logic [ADDR_WIDTH:0]         r_level;
    logic [15:0]                 r_cnt;
    logic [DATA_WIDTH-1:0]       r_i;
    logic [DATA_WIDTH-1:0]       r_q;
    logic                        r_valid;
    logic                        r_underrun;
    logic                        r_overflow;

    logic [15:0]                 w_eff_period;
    logic [ADDR_WIDTH:0]         w_eff_prime;
    logic                        w_active;
    logic                        w_tick;
    logic                        w_pop;
    logic                        w_under;
    logic                        w_push;
    logic                        w_ovf_ev;

    assign w_eff_period = (period_i == 16'd0) ? 16'd1 : period_i;
    assign w_eff_prime  = (prime_i == L_ZERO) ? L_ONE :
                          ((prime_i > L_DEPTH) ? L_DEPTH : prime_i);

    // Everything below is gated by en_i: a disabled cycle only flushes.
    assign w_active = en_i && (r_state != IDLE);
    assign w_tick   = en_i && (r_state == RUN) && (r_cnt == w_eff_period - 16'd1);
    assign w_pop    = w_tick && (r_level != L_ZERO);
    assign w_under  = w_tick && (r_level == L_ZERO);
    assign w_push   = w_active && Write_enable_i && ((r_level != L_DEPTH) || w_pop);
    assign w_ovf_ev = w_active && Write_enable_i && (r_level == L_DEPTH) && !w_pop;

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    w_state_nxt = PRIME;
            PRIME:   if (r_level >= w_eff_prime) w_state_nxt = RUN;
            RUN:     if (w_under) w_state_nxt = PRIME;
            default: w_state_nxt = IDLE;
        endcase
        if (!en_i) begin
            w_state_nxt = IDLE;
        end
    end

    // Counter only advances in RUN, so it is already zero on RUN entry.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_cnt <= 16'd0;
        end else if (!en_i || (r_state != RUN) || w_tick) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {I_interp_i, Q_interp_i};
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (!w_active) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + L_ONE;
                2'b01:   r_level <= r_level - L_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_i     <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
        end else if (w_pop) begin
            {r_i, r_q} <= r_mem[r_rptr];
            r_valid    <= 1'b1;
        end else if (w_under) begin
`ifdef INTPOL2_OUT_UNDERRUN_HOLD_EN
            r_valid <= 1'b1;
`else
            r_i     <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
        end
    end

    // Set events take priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_under)          r_underrun <= 1'b1;
            else if (clr_flags_i) r_underrun <= 1'b0;
            if (w_ovf_ev)         r_overflow <= 1'b1;
            else if (clr_flags_i) r_overflow <= 1'b0;
        end
    end

    assign Afull_o    = (r_level >= L_AF);
    assign I_o        = r_i;
    assign Q_o        = r_q;
    assign valid_o    = r_valid;
    assign level_o    = r_level;
    assign state_o    = r_state;
    assign underrun_o = r_underrun;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_intpol2_iq_out_pacer.sv
// Bench for intpol2_iq_out_pacer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_intpol2_iq_out_pacer;
  localparam int DW = 32;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst_a;
  logic          en_i;
  logic [15:0]   period_i;
  logic [3:0]    prime_i;
  logic          clr_flags_i;
  logic          we;
  logic [DW-1:0] i_in;
  logic [DW-1:0] q_in;
  logic          Afull_o;
  logic [DW-1:0] I_o;
  logic [DW-1:0] Q_o;
  logic          valid_o;
  logic [3:0]    level_o;
  logic [1:0]    state_o;
  logic          underrun_o;
  logic          overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  intpol2_iq_out_pacer dut (
    .clk(clk), .rst_a(rst_a), .en_i(en_i), .period_i(period_i), .prime_i(prime_i),
    .clr_flags_i(clr_flags_i), .Write_enable_i(we), .I_interp_i(i_in), .Q_interp_i(q_in),
    .Afull_o(Afull_o), .I_o(I_o), .Q_o(Q_o), .valid_o(valid_o), .level_o(level_o),
    .state_o(state_o), .underrun_o(underrun_o), .overflow_o(overflow_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a sample queue plus mode, tick counter and flags
  int          m_state = 0;
  int          m_cnt = 0;
  logic [63:0] m_q[$];
  logic [DW-1:0] m_i = '0;
  logic [DW-1:0] m_qo = '0;
  bit          m_valid = 0;
  bit          m_unf = 0;
  bit          m_ovf = 0;

  always @(posedge clk or posedge rst_a) begin : model
    int lvl;
    int eff_per;
    int eff_pr;
    bit tick, pop, und, push, ovf_ev;
    logic [63:0] s;
    if (rst_a) begin
      m_state = 0; m_q.delete(); m_cnt = 0;
      m_i = '0; m_qo = '0; m_valid = 0; m_unf = 0; m_ovf = 0;
    end else begin
      lvl     = m_q.size();
      eff_per = (period_i == 16'd0) ? 1 : int'(period_i);
      eff_pr  = (prime_i == 4'd0) ? 1 : ((int'(prime_i) > DEPTH) ? DEPTH : int'(prime_i));
      tick    = en_i && (m_state == 2) && (m_cnt == eff_per - 1);
      pop     = tick && (lvl > 0);
      und     = tick && (lvl == 0);
      push    = en_i && (m_state != 0) && we && ((lvl < DEPTH) || pop);
      ovf_ev  = en_i && (m_state != 0) && we && (lvl == DEPTH) && !pop;
      if (!en_i) begin
        m_state = 0; m_q.delete(); m_cnt = 0; m_valid = 0;
      end else begin
        m_valid = 0;
        if (pop) begin
          s = m_q.pop_front();
          m_i = s[63:32]; m_qo = s[31:0]; m_valid = 1;
        end else if (und) begin
`ifdef INTPOL2_OUT_UNDERRUN_HOLD_EN
          m_valid = 1;
`else
          m_i = '0; m_qo = '0;
`endif
        end
        if (push) m_q.push_back({i_in, q_in});
        case (m_state)
          0: m_state = 1;
          1: if (lvl >= eff_pr) begin m_state = 2; m_cnt = 0; end
          default: begin
            if (und) begin m_state = 1; m_cnt = 0; end
            else m_cnt = tick ? 0 : m_cnt + 1;
          end
        endcase
      end
      if (und) m_unf = 1; else if (clr_flags_i) m_unf = 0;
      if (ovf_ev) m_ovf = 1; else if (clr_flags_i) m_ovf = 0;
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    chk("cmp_state", 64'(state_o), 64'(m_state));
    chk("cmp_level", 64'(level_o), 64'(m_q.size()));
    chk("cmp_afull", 64'(Afull_o), 64'(m_q.size() >= DEPTH - 2));
    chk("cmp_valid", 64'(valid_o), 64'(m_valid));
    chk("cmp_i", 64'(I_o), 64'(m_i));
    chk("cmp_q", 64'(Q_o), 64'(m_qo));
    chk("cmp_underrun", 64'(underrun_o), 64'(m_unf));
    chk("cmp_overflow", 64'(overflow_o), 64'(m_ovf));
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write(input logic [DW-1:0] iv, input logic [DW-1:0] qv);
    we = 1'b1; i_in = iv; q_in = qv;
    step();
    we = 1'b0;
  endtask

  task automatic flush();
    en_i = 1'b0; clr_flags_i = 1'b1;
    step();
    clr_flags_i = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc);
    int n = 0;
    while (valid_o !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    chk("wait_valid_timeout", 64'(valid_o), 64'd1);
  endtask

  initial begin
    int n;
    rst_a = 1'b0; en_i = 1'b0; period_i = '0; prime_i = '0;
    clr_flags_i = 1'b0; we = 1'b0; i_in = '0; q_in = '0;
    #1 rst_a = 1'b1;
    #2;
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_afull", 64'(Afull_o), 64'd0);
    chk("rst_i", 64'(I_o), 64'd0);
    step(); step();
    rst_a = 1'b0;

    // pacing
    period_i = 16'd4; prime_i = 4'd2; en_i = 1'b1;
    step();
    chk("pace_prime_state", 64'(state_o), 64'd1);
    write(32'h11, 32'h22);
    write(32'h33, 32'h44);
    chk("pace_still_prime", 64'(state_o), 64'd1);
    step();
    chk("pace_run_state", 64'(state_o), 64'd2);
    chk("pace_run_level", 64'(level_o), 64'd2);
    wait_valid(10);
    chk("pace_first_i", 64'(I_o), 64'h11);
    chk("pace_first_q", 64'(Q_o), 64'h22);
    n = 0;
    do begin step(); n++; end while (valid_o !== 1'b1 && n < 10);
    chk("pace_interval", 64'(n), 64'd4);
    chk("pace_second_i", 64'(I_o), 64'h33);
    chk("pace_second_q", 64'(Q_o), 64'h44);
    step();
    chk("pace_valid_one_cycle", 64'(valid_o), 64'd0);

    // back-pressure and overflow
    flush();
    period_i = 16'd100; prime_i = 4'd2; en_i = 1'b1;
    step();
    for (int k = 1; k <= 10; k++) begin
      we = 1'b1; i_in = 32'(k); q_in = 32'(k + 16);
      step();
      chk("bp_level", 64'(level_o), 64'((k > 8) ? 8 : k));
      chk("bp_afull", 64'(Afull_o), 64'(k >= 6));
      chk("bp_overflow", 64'(overflow_o), 64'(k >= 9));
    end
    we = 1'b0; clr_flags_i = 1'b1;
    step();
    clr_flags_i = 1'b0;
    chk("bp_overflow_cleared", 64'(overflow_o), 64'd0);

    // push+pop at full level, one pop per cycle with period 0
    flush();
    period_i = 16'd0; prime_i = 4'd8; en_i = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) write(32'(k), 32'(k + 256));
    chk("full_level", 64'(level_o), 64'd8);
    chk("full_prime_state", 64'(state_o), 64'd1);
    step();
    chk("full_run_state", 64'(state_o), 64'd2);
    write(32'h99, 32'h9a);
    chk("full_pushpop_level", 64'(level_o), 64'd8);
    chk("full_pushpop_ovf", 64'(overflow_o), 64'd0);
    chk("full_pushpop_valid", 64'(valid_o), 64'd1);
    chk("full_pushpop_i", 64'(I_o), 64'd1);
    step();
    chk("full_next_valid", 64'(valid_o), 64'd1);
    chk("full_next_i", 64'(I_o), 64'd2);
    chk("full_next_level", 64'(level_o), 64'd7);

    // prime 0 and period 0
    flush();
    period_i = 16'd0; prime_i = 4'd0; en_i = 1'b1;
    step();
    write(32'hA, 32'hB);
    chk("p0_level", 64'(level_o), 64'd1);
    step();
    chk("p0_run", 64'(state_o), 64'd2);
    step();
    chk("p0_valid", 64'(valid_o), 64'd1);
    chk("p0_i", 64'(I_o), 64'hA);
    chk("p0_level_after", 64'(level_o), 64'd0);

    // underrun
    flush();
    period_i = 16'd2; prime_i = 4'd1; en_i = 1'b1;
    step();
    write(32'h55, 32'h66);
    wait_valid(10);
    chk("ur_first_i", 64'(I_o), 64'h55);
    step(); step();
    chk("ur_flag", 64'(underrun_o), 64'd1);
    chk("ur_state", 64'(state_o), 64'd1);
`ifdef INTPOL2_OUT_UNDERRUN_HOLD_EN
    chk("ur_valid", 64'(valid_o), 64'd1);
    chk("ur_i", 64'(I_o), 64'h55);
    chk("ur_q", 64'(Q_o), 64'h66);
`else
    chk("ur_valid", 64'(valid_o), 64'd0);
    chk("ur_i", 64'(I_o), 64'd0);
    chk("ur_q", 64'(Q_o), 64'd0);
`endif

    // disable mid-RUN
    flush();
    period_i = 16'd100; prime_i = 4'd1; en_i = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) write(32'(k), 32'(k));
    chk("dis_level", 64'(level_o), 64'd5);
    chk("dis_run", 64'(state_o), 64'd2);
    en_i = 1'b0;
    step();
    chk("dis_state", 64'(state_o), 64'd0);
    chk("dis_level0", 64'(level_o), 64'd0);
    chk("dis_valid", 64'(valid_o), 64'd0);

    // asynchronous reset mid-RUN
    period_i = 16'd2; prime_i = 4'd1; en_i = 1'b1;
    step();
    write(32'h77, 32'h88);
    write(32'h12, 32'h34);
    wait_valid(10);
    chk("rr_i_before", 64'(I_o), 64'h77);
    rst_a = 1'b1;
    #1;
    chk("rr_state", 64'(state_o), 64'd0);
    chk("rr_level", 64'(level_o), 64'd0);
    chk("rr_valid", 64'(valid_o), 64'd0);
    chk("rr_i", 64'(I_o), 64'd0);
    chk("rr_q", 64'(Q_o), 64'd0);
    chk("rr_afull", 64'(Afull_o), 64'd0);
    chk("rr_flags", 64'({underrun_o, overflow_o}), 64'd0);
    step();
    rst_a = 1'b0;
    step();
    chk("rr_reprime", 64'(state_o), 64'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_no_valid", 64'(valid_o), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
